// File: rtl/boot_loader_mc.sv
// Boot controller: handshake byte, length-prefixed instruction and data segments, completion byte, core release.
// Optional `define CHECKSUM_EN: each non-empty segment is followed by a 32-bit XOR checksum.
module boot_loader_mc #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned IMEM_AW    = 16,
    parameter int unsigned DMEM_AW    = 27,
    parameter int unsigned DMEM_BASE  = 0,
    parameter logic [7:0]  ACK_START  = 8'h99,
    parameter logic [7:0]  ACK_DONE   = 8'hAA,
    localparam int unsigned DATA_W    = 8 * WORD_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_req,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_done,
    output logic               core_run,
    output logic               busy,
    output logic               error,
    output logic [31:0]        prog_words
);

    typedef enum logic [3:0] {
        S_IDLE, S_TX_ACK0, S_HDR_I, S_LOAD_I, S_HDR_D,
        S_LOAD_D, S_WR_D, S_TX_ACK1, S_RUN, S_ERR
`ifdef CHECKSUM_EN
        , S_CHK_I, S_CHK_D, S_TX_ERR
`endif
    } state_e;

    localparam logic [2:0]  BCNT_LAST = 3'(WORD_BYTES - 1);
    localparam logic [63:0] IMEM_LIM  = 64'd1 << IMEM_AW;
    localparam logic [63:0] DMEM_LIM  = (64'd1 << DMEM_AW) - 64'(DMEM_BASE);

    state_e               state_q;
    logic [2:0]           bcnt_q;
    logic [31:0]          hdr_q, dcount_q, widx_q, prog_words_q;
    logic [DATA_W-1:0]    word_q;
    logic                 rx_ready_q, tx_valid_q, imem_we_q, dmem_req_q;
    logic                 core_run_q, busy_q, error_q;
    logic [7:0]           tx_data_q;
    logic [IMEM_AW-1:0]   imem_addr_q;
    logic [DMEM_AW-1:0]   dmem_addr_q;
    logic [DATA_W-1:0]    imem_wdata_q, dmem_wdata_q;
`ifdef CHECKSUM_EN
    logic [31:0]          csum_q;
`endif

    logic              rx_fire;
    logic [DATA_W-1:0] word_d;
    logic [31:0]       hdr_d, widx_inc;

    assign rx_fire  = rx_valid & rx_ready_q;
    assign widx_inc = widx_q + 32'd1;

    // Little-endian assembly: the byte counter selects the lane for the incoming byte.
    always_comb begin
        word_d = word_q;
        hdr_d  = hdr_q;
        for (int b = 0; b < WORD_BYTES; b++)
            if (bcnt_q == 3'(b)) word_d[8*b +: 8] = rx_data;
        for (int b = 0; b < 4; b++)
            if (bcnt_q[1:0] == 2'(b)) hdr_d[8*b +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bcnt_q       <= '0;
            hdr_q        <= '0;
            dcount_q     <= '0;
            widx_q       <= '0;
            prog_words_q <= '0;
            word_q       <= '0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q    <= S_TX_ACK0;
                    tx_data_q  <= ACK_START;
                    tx_valid_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                S_TX_ACK0: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    rx_ready_q <= 1'b1;
                    state_q    <= S_HDR_I;
                end
                S_HDR_I: if (rx_fire) begin
                    hdr_q <= hdr_d;
                    if (bcnt_q == 3'd3) begin
                        bcnt_q       <= '0;
                        prog_words_q <= hdr_d;
                        if ({32'd0, hdr_d} > IMEM_LIM) begin
                            state_q    <= S_ERR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end else if (hdr_d == 32'd0) begin
                            state_q <= S_HDR_D;
                        end else begin
                            state_q <= S_LOAD_I;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 3'd1;
                    end
                end
                S_LOAD_I: if (rx_fire) begin
                    word_q <= word_d;
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_q       <= '0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= IMEM_AW'(widx_q);
                        imem_wdata_q <= word_d;
`ifdef CHECKSUM_EN
                        csum_q       <= csum_q ^ 32'(word_d);
`endif
                        if (widx_inc == prog_words_q) begin
                            widx_q <= '0;
`ifdef CHECKSUM_EN
                            state_q <= S_CHK_I;
`else
                            state_q <= S_HDR_D;
`endif
                        end else begin
                            widx_q <= widx_inc;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 3'd1;
                    end
                end
                S_HDR_D: if (rx_fire) begin
                    hdr_q <= hdr_d;
                    if (bcnt_q == 3'd3) begin
                        bcnt_q   <= '0;
                        dcount_q <= hdr_d;
                        if ({32'd0, hdr_d} > DMEM_LIM) begin
                            state_q    <= S_ERR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end else if (hdr_d == 32'd0) begin
                            state_q    <= S_TX_ACK1;
                            rx_ready_q <= 1'b0;
                            tx_data_q  <= ACK_DONE;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD_D;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 3'd1;
                    end
                end
                S_LOAD_D: if (rx_fire) begin
                    word_q <= word_d;
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_q       <= '0;
                        rx_ready_q   <= 1'b0;
                        dmem_req_q   <= 1'b1;
                        dmem_addr_q  <= DMEM_AW'(DMEM_BASE) + DMEM_AW'(widx_q);
                        dmem_wdata_q <= word_d;
`ifdef CHECKSUM_EN
                        csum_q       <= csum_q ^ 32'(word_d);
`endif
                        state_q      <= S_WR_D;
                    end else begin
                        bcnt_q <= bcnt_q + 3'd1;
                    end
                end
                // No byte is consumed here, so a coincident rx byte simply waits.
                S_WR_D: if (dmem_done) begin
                    dmem_req_q <= 1'b0;
                    if (widx_inc == dcount_q) begin
                        widx_q <= '0;
`ifdef CHECKSUM_EN
                        rx_ready_q <= 1'b1;
                        state_q    <= S_CHK_D;
`else
                        state_q    <= S_TX_ACK1;
                        tx_data_q  <= ACK_DONE;
                        tx_valid_q <= 1'b1;
`endif
                    end else begin
                        widx_q     <= widx_inc;
                        rx_ready_q <= 1'b1;
                        state_q    <= S_LOAD_D;
                    end
                end
                S_TX_ACK1: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    core_run_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_RUN;
                end
`ifdef CHECKSUM_EN
                S_CHK_I, S_CHK_D: if (rx_fire) begin
                    hdr_q <= hdr_d;
                    if (bcnt_q == 3'd3) begin
                        bcnt_q <= '0;
                        csum_q <= '0;
                        if (hdr_d != csum_q) begin
                            state_q    <= S_TX_ERR;
                            rx_ready_q <= 1'b0;
                            tx_data_q  <= 8'hEE;
                            tx_valid_q <= 1'b1;
                        end else if (state_q == S_CHK_I) begin
                            state_q <= S_HDR_D;
                        end else begin
                            state_q    <= S_TX_ACK1;
                            rx_ready_q <= 1'b0;
                            tx_data_q  <= ACK_DONE;
                            tx_valid_q <= 1'b1;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 3'd1;
                    end
                end
                S_TX_ERR: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    error_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_ERR;
                end
`endif
                S_RUN, S_ERR: state_q <= state_q;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign core_run   = core_run_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign prog_words = prog_words_q;

endmodule

// File: tb/tb_boot_loader_mc.sv
// Scoreboard bench for boot_loader_mc: stimulus pushes expected tx bytes and memory writes,
// a monitor pops and compares whenever the DUT presents a handshake or write strobe.
module tb_boot_loader_mc;
    localparam int          WB   = 4;
    localparam int          DW   = 8 * WB;
    localparam int          IAW  = 16;
    localparam int          DAW  = 27;
    localparam int unsigned BASE = 32'h100;

    logic           clk = 1'b0;
    logic           rst, start, rx_valid, tx_ready, dmem_done;
    logic [7:0]     rx_data;
    logic           rx_ready, tx_valid, imem_we, dmem_req, core_run, busy, error;
    logic [7:0]     tx_data;
    logic [IAW-1:0] imem_addr;
    logic [DAW-1:0] dmem_addr;
    logic [DW-1:0]  imem_wdata, dmem_wdata;
    logic [31:0]    prog_words;

    always #5 clk = ~clk;

    boot_loader_mc #(.WORD_BYTES(WB), .IMEM_AW(IAW), .DMEM_AW(DAW), .DMEM_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_done(dmem_done),
        .core_run(core_run), .busy(busy), .error(error), .prog_words(prog_words)
    );

    typedef struct packed { logic [31:0] addr; logic [DW-1:0] data; } mem_t;
    logic [7:0] tx_exp[$];
    mem_t       imem_exp[$];
    mem_t       dmem_exp[$];
    int         tests = 0;
    int         fails = 0;
    int         done_delay = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: saw 0x%0h with nothing expected", nm, act);
    endtask

    // Transmit FIFO with random backpressure
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Memory controller: one-cycle done after a fixed or random wait
    initial begin
        automatic int  dly  = 0;
        automatic bit  pend = 0;
        dmem_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                dmem_done = 1'b0;
            end else if (dmem_done) begin
                dmem_done = 1'b0;
            end else if (dmem_req) begin
                if (!pend) begin
                    pend = 1;
                    dly = (done_delay >= 0) ? done_delay : int'($urandom_range(0, 6));
                end
                if (dly == 0) begin
                    dmem_done = 1'b1;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: sampled just after the falling edge, where all inputs for the next edge are settled
    initial begin
        logic [7:0] eb;
        mem_t       m;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (tx_valid && tx_ready) begin
                    if (tx_exp.size() == 0) unexpected("tx_unexpected", tx_data);
                    else begin eb = tx_exp.pop_front(); chk("tx_byte", tx_data, eb); end
                end
                if (imem_we) begin
                    if (imem_exp.size() == 0) unexpected("imem_unexpected", imem_addr);
                    else begin
                        m = imem_exp.pop_front();
                        chk("imem_addr", imem_addr, m.addr);
                        chk("imem_wdata", imem_wdata, m.data);
                    end
                end
                if (dmem_req && dmem_done) begin
                    if (dmem_exp.size() == 0) unexpected("dmem_unexpected", dmem_addr);
                    else begin
                        m = dmem_exp.pop_front();
                        chk("dmem_addr", dmem_addr, m.addr);
                        chk("dmem_wdata", dmem_wdata, m.data);
                    end
                end
                if (dmem_req) chk("rx_ready_during_wr", rx_ready, 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        automatic int g = 0;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!rx_ready) begin
            unexpected("rx_timeout", b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] v);
        for (int b = 0; b < 4; b++) send_byte(v[8*b +: 8]);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int b = 0; b < WB; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; done_delay = -1;
        @(negedge clk);
        #1;
        tx_exp.delete(); imem_exp.delete(); dmem_exp.delete();
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_core_run", core_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_prog_words", prog_words, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_for(input bit use_err, input string nm);
        automatic int g = 0;
        while (!(use_err ? error : core_run) && g < 4000) begin
            @(negedge clk);
            g++;
        end
        #1;
        chk(nm, use_err ? error : core_run, 1);
    endtask

    // Whole load: model is the byte stream plus the list of words each memory must see
    task automatic run_load(input int ni, input int nd, input bit fixed);
        logic [DW-1:0] w;
        logic [31:0]   ck;
        tx_exp.push_back(8'h99);
        tx_exp.push_back(8'hAA);
        @(negedge clk);
        start = 1'b1;
        send32(32'(ni));
        start = 1'b0;
        ck = '0;
        for (int i = 0; i < ni; i++) begin
            w = fixed ? ((i == 0) ? DW'(32'h44332211) : DW'(32'h88776655)) : DW'($urandom);
            imem_exp.push_back('{addr: 32'(i), data: w});
            ck ^= 32'(w);
            send_word(w);
        end
`ifdef CHECKSUM_EN
        if (ni > 0) send32(ck);
`endif
        ck = '0;
        send32(32'(nd));
        for (int i = 0; i < nd; i++) begin
            w = DW'($urandom);
            dmem_exp.push_back('{addr: BASE + 32'(i), data: w});
            ck ^= 32'(w);
            send_word(w);
        end
`ifdef CHECKSUM_EN
        if (nd > 0) send32(ck);
`endif
        wait_for(1'b0, "core_run");
        chk("run_error", error, 0);
        chk("run_busy", busy, 0);
        chk("run_rx_ready", rx_ready, 0);
        chk("prog_words", prog_words, 32'(ni));
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        #1;
        chk("run_hold", core_run, 1);
        chk("tx_pending", tx_exp.size(), 0);
        chk("imem_pending", imem_exp.size(), 0);
        chk("dmem_pending", dmem_exp.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        do_reset();

        // Fixed instruction words, data writes each acknowledged after 5 cycles
        done_delay = 5;
        run_load(2, 3, 1'b1);
        do_reset();
        run_load(0, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            do_reset();
            run_load(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 1'b0);
        end

        // Instruction count one past the 2^IMEM_AW limit
        do_reset();
        tx_exp.push_back(8'h99);
        @(negedge clk);
        start = 1'b1;
        send32(32'h0001_0001);
        start = 1'b0;
        wait_for(1'b1, "hdr_error");
        repeat (3) @(negedge clk);
        #1;
        chk("err_core_run", core_run, 0);
        chk("err_busy", busy, 0);
        chk("err_rx_ready", rx_ready, 0);
        chk("err_sticky", error, 1);
        chk("err_tx_pending", tx_exp.size(), 0);

        // Reset in the middle of a data word, then a clean reload
        do_reset();
        begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            tx_exp.push_back(8'h99);
            imem_exp.push_back('{addr: 32'd0, data: w});
            @(negedge clk);
            start = 1'b1;
            send32(32'd1);
            start = 1'b0;
            send_word(w);
`ifdef CHECKSUM_EN
            send32(32'(w));
`endif
            send32(32'd4);
            send_byte(8'h5A);
            send_byte(8'hA5);
            repeat (2) @(negedge clk);
            #1;
            chk("mid_imem_pending", imem_exp.size(), 0);
        end
        do_reset();
        run_load(3, 4, 1'b0);

`ifdef CHECKSUM_EN
        // Corrupted instruction checksum
        do_reset();
        begin
            logic [DW-1:0] w;
            logic [31:0]   ck;
            ck = '0;
            tx_exp.push_back(8'h99);
            tx_exp.push_back(8'hEE);
            @(negedge clk);
            start = 1'b1;
            send32(32'd2);
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                w = DW'($urandom);
                imem_exp.push_back('{addr: 32'(i), data: w});
                ck ^= 32'(w);
                send_word(w);
            end
            send32(ck ^ 32'h1);
            wait_for(1'b1, "ck_error");
            chk("ck_core_run", core_run, 0);
            chk("ck_tx_pending", tx_exp.size(), 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
